// File: rtl/des_host_pkg.sv
// Shared host-side constants and frame type, used by the host framer and the DES core.
package des_host_pkg;

    localparam int unsigned HOST_FRAME_BYTES   = 16;
    localparam int unsigned HOST_WARMUP_CYCLES = 3;

    typedef logic [HOST_FRAME_BYTES*8-1:0] host_frame_t;

endpackage

// File: rtl/host_rx_framer_if.sv
// Synchronized host byte link from the strobe synchronizer to the frame assembler.
interface host_rx_framer_if;

    logic       strobe;
    logic       sel;
    logic [7:0] data;

    modport master (output strobe, sel, data);
    modport slave  (input  strobe, sel, data);

endinterface

// File: rtl/host_strobe_sync.sv
// Brings the asynchronous host strobe, selects and data into the CLK domain and flags
// every SLOWCLK edge, with the data byte delayed to line up with the strobe.
module host_strobe_sync
    import des_host_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     slowclk_i,
    input  logic                     cs_i,
    input  logic                     wr_i,
    input  logic [7:0]               pc_i,
    host_rx_framer_if.master         link_o
);

    // One extra SLOWCLK stage beyond the synchronizer gives the edge-detect reference.
    logic [SYNC_STAGES:0]            slow_q;
    logic [SYNC_STAGES-1:0]          cs_q;
    logic [SYNC_STAGES-1:0]          wr_q;
    logic [SYNC_STAGES-1:0][7:0]     pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slow_q <= '0;
            cs_q   <= '0;
            wr_q   <= '0;
            pc_q   <= '0;
        end else begin
            slow_q[0] <= slowclk_i;
            cs_q[0]   <= cs_i;
            wr_q[0]   <= wr_i;
            pc_q[0]   <= pc_i;
            for (int unsigned i = 1; i <= SYNC_STAGES; i++) begin
                slow_q[i] <= slow_q[i-1];
            end
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                cs_q[i] <= cs_q[i-1];
                wr_q[i] <= wr_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
        end
    end

    assign link_o.strobe = slow_q[SYNC_STAGES] ^ slow_q[SYNC_STAGES-1];
    assign link_o.sel    = cs_q[SYNC_STAGES-1] & wr_q[SYNC_STAGES-1];
    assign link_o.data   = pc_q[SYNC_STAGES-1];

endmodule

// File: rtl/host_rx_framer.sv
// Assembles host bytes written on SLOWCLK edges into FRAME_BYTES-wide frames and
// offers them through a single-entry valid/ready holding register.
module host_rx_framer
    import des_host_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = HOST_FRAME_BYTES,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             SLOWCLK,
    input  logic                             CS,
    input  logic                             WR,
    input  logic [7:0]                       pc,
    output logic [FRAME_BYTES*8-1:0]         out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overflow,
    output logic [$clog2(FRAME_BYTES+1)-1:0] byte_cnt
);

    localparam int unsigned   FW          = FRAME_BYTES * 8;
    localparam int unsigned   CW          = $clog2(FRAME_BYTES + 1);
    localparam int unsigned   WW          = $clog2(HOST_WARMUP_CYCLES + 1);
    localparam logic [CW-1:0] LAST_IDX    = CW'(FRAME_BYTES - 1);
    localparam logic [WW-1:0] WARMUP_LOAD = WW'(HOST_WARMUP_CYCLES);

    host_rx_framer_if link ();

    host_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .slowclk_i (SLOWCLK),
        .cs_i      (CS),
        .wr_i      (WR),
        .pc_i      (pc),
        .link_o    (link)
    );

    logic [WW-1:0] warm_q, warm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] asm_q, asm_d;
    logic [FW-1:0] hold_q, hold_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [FW-1:0] shifted;
    logic          capture;
    logic          complete;
    logic          transfer;

    always_comb begin
        warm_d   = (warm_q != '0) ? warm_q - 1'b1 : warm_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        hold_d   = hold_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        complete = 1'b0;
        // Strobes seen while the synchronizers settle after reset are start-up artefacts.
        capture  = link.strobe & link.sel & (warm_q == '0);
        transfer = valid_q & out_ready;
        shifted  = {asm_q[FW-9:0], link.data};

        if (!link.sel) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (capture) begin
            if (cnt_q == LAST_IDX) begin
                complete = 1'b1;
                cnt_d    = '0;
                asm_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                asm_d = shifted;
            end
        end

        if (transfer) begin
            valid_d = 1'b0;
        end
        // A frame finishing on the draining edge replaces the departing one.
        if (complete) begin
            if (!valid_q || transfer) begin
                hold_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            warm_q  <= WARMUP_LOAD;
            cnt_q   <= '0;
            asm_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = hold_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;
    assign byte_cnt  = cnt_q;

endmodule
